instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// Front-end stage directly upstream of the RV32I instruction decoder. Holds the PC and fetches
// 32-bit words from instruction memory with a req/ack handshake. Presents each word, with its PC,
// to the decoder through a one-entry valid/ready output buffer. Handles redirects from
// branch/jump resolution and stalls fetch for a fixed time after a Zihintpause PAUSE.
// PARAMETERS
// RESET_PC      32'h0000_0000  PC of first fetch after reset; bits[1:0] must be 0
// PAUSE_CYCLES  16             fetch-idle cycles after a PAUSE word is captured; 0 disables stall
// PAUSE_WORD    32'h0100_000F  exact PAUSE encoding (FENCE pred=W succ=0 fm=0 rd=x0 rs1=x0)
// PORTS
// clk          in   1   clock; all state changes on rising edge
// reset        in   1   synchronous, active-high reset
// imem_req     out  1   fetch request; address in imem_addr
// imem_addr    out  32  fetch address (= current PC)
// imem_ack     in   1   memory accepts; transfer occurs in any cycle with imem_req && imem_ack
// imem_rdata   in   32  instruction word; valid in the transfer cycle only
// instr_valid  out  1   output buffer holds an instruction for the decoder
// instr        out  32  buffered instruction word (decoder input)
// instr_pc     out  32  PC of the buffered instruction
// instr_ready  in   1   decoder consumes; handoff when instr_valid && instr_ready
// redirect     in   1   one-cycle pulse: flush and restart fetch at redirect_pc
// redirect_pc  in   32  new PC; bits[1:0] are forced to 0
// pausing      out  1   high while the stall counter is running (state PAUSE)
// BEHAVIOUR
// - Reset (reset high at a clock edge): pc=RESET_PC, state=FETCH, cnt=0, instr_valid=0, instr=0,
//   instr_pc=0. imem_req is forced to 0 combinationally while reset is high.
// - imem_addr = pc at all times. imem_req = !reset && state==FETCH && (!instr_valid || instr_ready).
//   The buffer is empty or draining this cycle, so sustained throughput is 1 instruction per cycle.
// - Transfer cycle (req && ack, no redirect): next edge instr<=imem_rdata, instr_pc<=pc,
//   instr_valid<=1, pc<=pc+4. pc wraps modulo 2^32 (32'hFFFF_FFFC+4 -> 0). Latency is 1 cycle
//   from ack to instr_valid.
// - Handoff without a new transfer: next edge instr_valid<=0. instr and instr_pc hold their values.
// - instr_valid && !instr_ready: instr and instr_pc are stable and imem_req=0, so no new transfer.
// - FSM FETCH -> PAUSE: on a transfer whose imem_rdata==PAUSE_WORD and PAUSE_CYCLES>0, load
//   cnt<=PAUSE_CYCLES-1. The PAUSE word itself is still delivered to the decoder as a normal fence.
// - FSM PAUSE: imem_req=0 and pausing=1. While cnt!=0, cnt<=cnt-1. When cnt==0, state<=FETCH.
//   Fetch restarts exactly PAUSE_CYCLES cycles after the PAUSE transfer edge.
// - Output handoff continues normally during PAUSE.
// - Redirect (highest priority, any state): next edge pc<={redirect_pc[31:2],2'b00},
//   instr_valid<=0, state<=FETCH, cnt<=0.
//   - A transfer in the redirect cycle is discarded: no buffer write and no pc+4.
//   - A handoff in the redirect cycle still counts as consumed.
//   - The first request at the new PC is issued in the cycle after the redirect.
// - Back-to-back redirects: the last one wins.
// - Reset mid-operation overrides redirect, pause and transfers. An in-flight ack during reset is
//   ignored because imem_req=0.
// - imem_ack with imem_req=0 is ignored.
// - Counter width is $clog2(PAUSE_CYCLES+1), minimum 1 bit.
// TESTING
// - Reset, ack tied 1, ready tied 1 -> imem_addr 0,4,8,...; instr_valid high from cycle 2;
//   1 instr/cycle with matching instr_pc.
// - ready=0 for 3 cycles while valid -> imem_req=0, instr/instr_pc stable;
//   ready=1 -> next PC fetched, no word lost or duplicated.
// - Fetch of 32'h0100000F, PAUSE_CYCLES=16 -> PAUSE word delivered; pausing high 16 cycles;
//   imem_req low 16 cycles; then fetch resumes at PAUSE pc+4.
// - redirect=1, redirect_pc=32'h0000_0203 in the same cycle as an ack -> ack data dropped;
//   instr_valid=0 next cycle; next imem_addr=32'h200.
// - redirect during PAUSE (cnt=9) -> pausing drops next cycle; fetch at redirect_pc.
//   Also: pc=32'hFFFF_FFFC transfer -> next imem_addr=0.
// - reset asserted mid-stream with instr_valid=1 and cnt>0 -> next cycle instr_valid=0,
//   pausing=0, imem_addr=RESET_PC; imem_req=0 while reset is high.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front-end: PC, imem req/ack fetch, one-entry valid/ready buffer to the decoder,
// redirect flush and a fixed fetch stall after a Zihintpause PAUSE.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          PAUSE_CYCLES = 16,
    parameter logic [31:0] PAUSE_WORD   = 32'h0100_000F
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        pausing
);

    localparam int CNT_W = (PAUSE_CYCLES > 0) ? (($clog2(PAUSE_CYCLES + 1) > 0) ? $clog2(PAUSE_CYCLES + 1) : 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (PAUSE_CYCLES > 0) ? CNT_W'(PAUSE_CYCLES - 1) : '0;
    localparam bit PAUSE_EN = (PAUSE_CYCLES > 0);

    typedef enum logic {
        FETCH = 1'b0,
        PAUSE = 1'b1
    } state_t;

    state_t           state;
    logic [31:0]      pc;
    logic [CNT_W-1:0] cnt;
    logic             xfer;
    logic             handoff;
    logic             is_pause;

    // Only request when the buffer is empty or being drained this cycle.
    assign imem_req  = !reset && (state == FETCH) && (!instr_valid || instr_ready);
    assign imem_addr = pc;
    assign xfer      = imem_req && imem_ack;
    assign handoff   = instr_valid && instr_ready;
    assign is_pause  = PAUSE_EN && (imem_rdata == PAUSE_WORD);
    assign pausing   = (state == PAUSE);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            state       <= FETCH;
            cnt         <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else if (redirect) begin
            // Any transfer this cycle is dropped; a handoff this cycle is simply consumed.
            pc          <= redirect_pc & 32'hFFFF_FFFC;
            state       <= FETCH;
            cnt         <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (xfer) begin
                instr       <= imem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + 32'd4;
            end else if (handoff) begin
                instr_valid <= 1'b0;
            end

            case (state)
                FETCH: begin
                    if (xfer && is_pause) begin
                        state <= PAUSE;
                        cnt   <= CNT_LOAD;
                    end
                end
                PAUSE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else           state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, stall, PAUSE, redirects, wrap, mid-run reset.
module tb_instr_fetch_unit;

    localparam logic [31:0] PW = 32'h0100_000F;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pausing;

    logic [31:0] pause_addr = 32'h1;
    logic [31:0] pc_m;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Memory image: address scrambled, except one chosen address that returns PAUSE.
    assign imem_rdata = (imem_addr == pause_addr) ? PW : (imem_addr ^ 32'h1234_5678);

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    instr_fetch_unit #(.RESET_PC(32'h0), .PAUSE_CYCLES(16), .PAUSE_WORD(PW)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .pausing(pausing)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ack = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        tick(); tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got %b want 0", imem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        total++; if ({instr, instr_pc} !== 64'h0) begin bad++; $display("FAIL rst_instr got %h/%h want 0", instr, instr_pc); end
        total++; if (pausing !== 1'b0) begin bad++; $display("FAIL rst_pausing got %b want 0", pausing); end
        reset = 1'b0;
        #1;
        pc_m = 32'h0;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 6; k++) begin
            total++; if (imem_req !== 1'b1 || imem_addr !== pc_m) begin bad++; $display("FAIL stream_req k=%0d got %b/%h want 1/%h", k, imem_req, imem_addr, pc_m); end
            if (k > 0) begin
                total++; if (instr_valid !== 1'b1 || instr_pc !== pc_m - 4 || instr !== word_at(pc_m - 4)) begin
                    bad++; $display("FAIL stream_out k=%0d got %b/%h/%h want 1/%h/%h", k, instr_valid, instr_pc, instr, pc_m - 4, word_at(pc_m - 4)); end
            end
            tick();
            pc_m += 4;
        end
    endtask

    task automatic test_stall();
        instr_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (imem_req !== 1'b0 || imem_addr !== pc_m) begin bad++; $display("FAIL stall_req i=%0d got %b/%h want 0/%h", i, imem_req, imem_addr, pc_m); end
            total++; if (instr_valid !== 1'b1 || instr_pc !== pc_m - 4 || instr !== word_at(pc_m - 4)) begin
                bad++; $display("FAIL stall_hold i=%0d got %b/%h/%h want 1/%h/%h", i, instr_valid, instr_pc, instr, pc_m - 4, word_at(pc_m - 4)); end
            tick();
        end
        instr_ready = 1'b1;
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stall_release got %b want 1", imem_req); end
        tick();
        total++; if (instr_pc !== pc_m || instr !== word_at(pc_m)) begin bad++; $display("FAIL stall_next got %h/%h want %h/%h", instr_pc, instr, pc_m, word_at(pc_m)); end
        pc_m += 4;
        total++; if (imem_addr !== pc_m) begin bad++; $display("FAIL stall_addr got %h want %h", imem_addr, pc_m); end
    endtask

    task automatic test_pause();
        int hi;
        pause_addr = pc_m;
        tick();
        pause_addr = 32'h1;
        total++; if (instr_valid !== 1'b1 || instr !== PW || instr_pc !== pc_m) begin bad++; $display("FAIL pause_word got %b/%h/%h want 1/%h/%h", instr_valid, instr, instr_pc, PW, pc_m); end
        pc_m += 4;
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            if (pausing === 1'b1 && imem_req === 1'b0) hi++;
            tick();
        end
        total++; if (hi !== 16) begin bad++; $display("FAIL pause_len got %0d want 16", hi); end
        total++; if (pausing !== 1'b0 || imem_req !== 1'b1 || imem_addr !== pc_m) begin bad++; $display("FAIL pause_resume got %b/%b/%h want 0/1/%h", pausing, imem_req, imem_addr, pc_m); end
    endtask

    task automatic test_redirect_ack();
        tick(); tick();
        pc_m += 8;
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        #1;
        total++; if (instr_valid !== 1'b0 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin
            bad++; $display("FAIL redir_ack got %b/%h/%b want 0/00000200/1", instr_valid, imem_addr, imem_req); end
        tick();
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== word_at(32'h200)) begin
            bad++; $display("FAIL redir_first got %b/%h/%h want 1/00000200/%h", instr_valid, instr_pc, instr, word_at(32'h200)); end
        pc_m = 32'h204;
    endtask

    task automatic test_redirect_pause();
        pause_addr = pc_m;
        tick();
        pause_addr = 32'h1;
        for (int i = 0; i < 6; i++) tick();
        total++; if (pausing !== 1'b1) begin bad++; $display("FAIL rp_pausing got %b want 1", pausing); end
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        #1;
        total++; if (pausing !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL rp_restart got %b/%b/%h want 0/1/fffffffc", pausing, imem_req, imem_addr); end
        tick();
        total++; if (imem_addr !== 32'h0 || instr_pc !== 32'hFFFF_FFFC || instr !== word_at(32'hFFFF_FFFC)) begin
            bad++; $display("FAIL wrap got %h/%h/%h want 00000000/fffffffc/%h", imem_addr, instr_pc, instr, word_at(32'hFFFF_FFFC)); end
        pc_m = 32'h0;
    endtask

    task automatic test_reset_mid();
        pause_addr = pc_m;
        tick();
        pause_addr = 32'h1;
        instr_ready = 1'b0;
        tick(); tick();
        total++; if (instr_valid !== 1'b1 || pausing !== 1'b1) begin bad++; $display("FAIL rm_pre got %b/%b want 1/1", instr_valid, pausing); end
        reset = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rm_req got %b want 0", imem_req); end
        tick();
        total++; if (instr_valid !== 1'b0 || pausing !== 1'b0 || imem_addr !== 32'h0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL rm_state got %b/%b/%h/%b want 0/0/00000000/0", instr_valid, pausing, imem_addr, imem_req); end
        reset = 1'b0; instr_ready = 1'b1;
        #1;
        tick();
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== word_at(32'h0)) begin
            bad++; $display("FAIL rm_first got %b/%h/%h want 1/00000000/%h", instr_valid, instr_pc, instr, word_at(32'h0)); end
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_pc = 32'h0000_0302;
        tick();
        redirect = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h300 || instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_addr got %h/%b want 00000300/0", imem_addr, instr_valid); end
        tick();
        total++; if (instr_pc !== 32'h300 || instr !== word_at(32'h300) || imem_addr !== 32'h304) begin
            bad++; $display("FAIL b2b_first got %h/%h/%h want 00000300/%h/00000304", instr_pc, instr, imem_addr, word_at(32'h300)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_pause();
        test_redirect_ack();
        test_redirect_pause();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
